// File: rtl/bytecode_pkg.sv
// Shared bytecode definitions for the fetch controller and the decoder.
// Contents: dispatch FSM state enum, opcode constants, the decoder
// instruction word layout, and helpers for instruction length and
// return detection.
package bytecode_pkg;

   localparam int unsigned BC_BYTE_W     = 8;
   localparam int unsigned BC_ADDR_W     = 16;
   localparam int unsigned BC_INSTR_W    = 2 * BC_BYTE_W;
   localparam int unsigned BC_FIFO_DEPTH = 4;

   localparam logic [BC_BYTE_W-1:0] OP_BIPUSH  = 8'h10;
   localparam logic [BC_BYTE_W-1:0] OP_ILOAD   = 8'h15;
   localparam logic [BC_BYTE_W-1:0] OP_LLOAD   = 8'h16;
   localparam logic [BC_BYTE_W-1:0] OP_DLOAD   = 8'h18;
   localparam logic [BC_BYTE_W-1:0] OP_IRETURN = 8'hAC;
   localparam logic [BC_BYTE_W-1:0] OP_DRETURN = 8'hAF;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_ACCEPT,
      WAIT_DONE,
      HALTED
   } fetch_state_e;

   // Decoder instruction word: opcode in the upper byte.
   typedef struct packed {
      logic [BC_BYTE_W-1:0] opcode;
      logic [BC_BYTE_W-1:0] operand;
   } instr_word_t;

   // Instruction length in bytes (1 or 2) for a given opcode.
   function automatic logic [1:0] instr_len(input logic [BC_BYTE_W-1:0] op);
      case (op)
         OP_BIPUSH, OP_ILOAD, OP_LLOAD, OP_DLOAD: instr_len = 2'd2;
         default:                                 instr_len = 2'd1;
      endcase
   endfunction

   function automatic logic is_return(input logic [BC_BYTE_W-1:0] op);
      is_return = (op == OP_IRETURN) || (op == OP_DRETURN);
   endfunction

endpackage

// File: rtl/byte_prefetch_fifo.sv
// Byte FIFO feeding the dispatch FSM.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   flush            empty the FIFO (wins over push/pop)
//   push, push_data  write one byte
//   pop_len          bytes to drop from the head this cycle (0, 1 or 2)
//   head, head_next  peek at the head byte and the byte behind it
//   count            bytes currently stored
module byte_prefetch_fifo #(
   parameter int unsigned BYTE  = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    push,
   input  logic [BYTE-1:0]         push_data,
   input  logic [1:0]              pop_len,
   output logic [BYTE-1:0]         head,
   output logic [BYTE-1:0]         head_next,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [BYTE-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         rd_ptr <= rd_ptr + PTR_W'(pop_len);
         count  <= count + CNT_W'(push) - CNT_W'(pop_len);
      end
   end

   assign head      = mem[rd_ptr];
   assign head_next = mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/bytecode_fetch_ctrl.sv
// Bytecode fetch controller: prefetches bytes from instruction memory
// into a small FIFO, assembles {opcode, operand} words, runs the
// start/ready handshake with the decoder and advances the PC by the
// instruction length. Halts after a return opcode completes.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   enable                     allow dispatch to the decoder
//   pc_load, pc_load_value     redirect PC and flush (IDLE/HALTED only)
//   mem_req, mem_addr          memory read request (held until mem_ack)
//   mem_ack, mem_data          one-cycle acknowledge with read byte
//   dec_start                  one-cycle start pulse to the decoder
//   dec_ready                  decoder idle (1) / busy (0)
//   dec_instr                  {opcode, operand-or-0}, stable until done
//   pc                         address of the instruction at the FIFO head
//   halted                     a return opcode completed
//   busy                       dispatch FSM active
//   dec_timeout                (DEC_WATCHDOG_EN only) decoder watchdog fired
// Optional feature macro: DEC_WATCHDOG_EN.
module bytecode_fetch_ctrl
   import bytecode_pkg::*;
#(
   parameter int unsigned BYTE       = BC_BYTE_W,
   parameter int unsigned ADDR_W     = BC_ADDR_W,
   parameter int unsigned INSTR_W    = BC_INSTR_W,
   parameter int unsigned FIFO_DEPTH = BC_FIFO_DEPTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               pc_load,
   input  logic [ADDR_W-1:0]  pc_load_value,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [BYTE-1:0]    mem_data,
   output logic               dec_start,
   input  logic               dec_ready,
   output logic [INSTR_W-1:0] dec_instr,
   output logic [ADDR_W-1:0]  pc,
   output logic               halted,
   output logic               busy
`ifdef DEC_WATCHDOG_EN
   ,
   output logic               dec_timeout
`endif
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e      state;
   fetch_state_e      state_next;
   logic [CNT_W-1:0]  fifo_count;
   logic [BYTE-1:0]   fifo_head;
   logic [BYTE-1:0]   fifo_head_nx;
   logic [1:0]        head_len;
   logic [1:0]        cur_len;
   logic [1:0]        pop_len;
   logic              head_ready;
   logic              load_fire;
   logic              ack_take;
   logic              push;
   logic              fetch_ok;
   logic              latch_instr;
   logic [ADDR_W-1:0] fetch_addr;
   logic              discard_pend;
   instr_word_t       instr_q;

`ifdef DEC_WATCHDOG_EN
   logic [7:0]        wd_cnt;
   logic              timeout_fire;
`endif

   byte_prefetch_fifo #(
      .BYTE  (BYTE),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (load_fire),
      .push      (push),
      .push_data (mem_data),
      .pop_len   (pop_len),
      .head      (fifo_head),
      .head_next (fifo_head_nx),
      .count     (fifo_count)
   );

   assign head_len   = instr_len(fifo_head);
   assign cur_len    = instr_len(instr_q.opcode);
   assign head_ready = (fifo_count >= CNT_W'(head_len));
   assign load_fire  = pc_load && ((state == IDLE) || (state == HALTED));
   assign ack_take   = mem_req && mem_ack;
   // Bytes from the stream abandoned by pc_load are dropped.
   assign push       = ack_take && !discard_pend && !load_fire;
   // No outstanding request here (mem_req=0), so count alone bounds occupancy.
   assign fetch_ok   = !mem_req && !discard_pend && !load_fire &&
                       (fifo_count < CNT_W'(FIFO_DEPTH)) && (state_next != HALTED);
   assign dec_instr  = instr_q;

   // Fetch side: single outstanding request, address advances on each kept byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_req      <= 1'b0;
         mem_addr     <= '0;
         fetch_addr   <= '0;
         discard_pend <= 1'b0;
      end else if (load_fire) begin
         fetch_addr   <= pc_load_value;
         discard_pend <= mem_req && !mem_ack;
         if (ack_take) mem_req <= 1'b0;
      end else if (ack_take) begin
         mem_req <= 1'b0;
         if (discard_pend) discard_pend <= 1'b0;
         else              fetch_addr   <= fetch_addr + ADDR_W'(1);
      end else if (fetch_ok) begin
         mem_req  <= 1'b1;
         mem_addr <= fetch_addr;
      end
   end

   // Dispatch FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Dispatch FSM next state and control strobes.
   always_comb begin
      state_next  = state;
      pop_len     = 2'd0;
      latch_instr = 1'b0;
`ifdef DEC_WATCHDOG_EN
      timeout_fire = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (!load_fire && enable && dec_ready && head_ready) begin
               state_next  = ISSUE;
               latch_instr = 1'b1;
            end
         end
         ISSUE:       state_next = WAIT_ACCEPT;
         WAIT_ACCEPT: if (!dec_ready) state_next = WAIT_DONE;
         WAIT_DONE: begin
            if (dec_ready) begin
               pop_len    = cur_len;
               state_next = is_return(instr_q.opcode) ? HALTED : IDLE;
            end
         end
         HALTED:      if (load_fire) state_next = IDLE;
         default:     state_next = IDLE;
      endcase
`ifdef DEC_WATCHDOG_EN
      // 255th cycle without progress abandons the instruction.
      if (((state == WAIT_ACCEPT) || (state == WAIT_DONE)) &&
          (state_next == state) && (wd_cnt == 8'd254)) begin
         state_next   = HALTED;
         timeout_fire = 1'b1;
      end
`endif
   end

   // Registered outputs and PC.
   always_ff @(posedge clk) begin
      if (reset) begin
         dec_start <= 1'b0;
         busy      <= 1'b0;
         halted    <= 1'b0;
         pc        <= '0;
         instr_q   <= '0;
      end else begin
         dec_start <= (state_next == ISSUE);
         busy      <= (state_next == ISSUE) || (state_next == WAIT_ACCEPT) ||
                      (state_next == WAIT_DONE);
         halted    <= (state_next == HALTED);
         if (latch_instr) begin
            instr_q.opcode  <= fifo_head;
            instr_q.operand <= (head_len == 2'd2) ? fifo_head_nx : '0;
         end
         if (load_fire)              pc <= pc_load_value;
         else if (pop_len != 2'd0)   pc <= pc + ADDR_W'(pop_len);
      end
   end

`ifdef DEC_WATCHDOG_EN
   // Watchdog: counts stalled cycles in the decoder wait states.
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt      <= 8'd0;
         dec_timeout <= 1'b0;
      end else begin
         if (((state == WAIT_ACCEPT) || (state == WAIT_DONE)) && (state_next == state))
            wd_cnt <= wd_cnt + 8'd1;
         else
            wd_cnt <= 8'd0;
         if (load_fire)         dec_timeout <= 1'b0;
         else if (timeout_fire) dec_timeout <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_bytecode_fetch_ctrl.sv
// Directed bench for bytecode_fetch_ctrl with a byte memory responder
// and a decoder model (3-cycle busy, or stuck busy).
module tb_bytecode_fetch_ctrl;
   import bytecode_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        pc_load;
   logic [15:0] pc_load_value;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_data;
   logic        dec_start;
   logic        dec_ready;
   logic [15:0] dec_instr;
   logic [15:0] pc;
   logic        halted;
   logic        busy;
`ifdef DEC_WATCHDOG_EN
   logic        dec_timeout;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  img [65536];
   int          ack_stop;     // ack only while total acks < ack_stop (negative: no limit)
   int          mem_lat;
   int          wait_cnt;
   logic [15:0] addr_log[$];
   bit          dec_stuck;
   int          dec_busy;
   logic [15:0] dlog_instr[$];
   logic [15:0] dlog_pc[$];

   bytecode_fetch_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .pc_load       (pc_load),
      .pc_load_value (pc_load_value),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_data      (mem_data),
      .dec_start     (dec_start),
      .dec_ready     (dec_ready),
      .dec_instr     (dec_instr),
      .pc            (pc),
      .halted        (halted),
      .busy          (busy)
`ifdef DEC_WATCHDOG_EN
      ,
      .dec_timeout   (dec_timeout)
`endif
   );

   always #5 clk = ~clk;

   // Memory responder: acks one cycle at a time after mem_lat cycles.
   always @(negedge clk) begin
      if (reset) begin
         mem_ack  = 1'b0;
         mem_data = 8'h00;
         wait_cnt = 0;
      end else if (mem_ack) begin
         mem_ack = 1'b0;
      end else if (mem_req && (ack_stop < 0 || addr_log.size() < ack_stop)) begin
         if (wait_cnt >= mem_lat) begin
            mem_ack  = 1'b1;
            mem_data = img[mem_addr];
            addr_log.push_back(mem_addr);
            wait_cnt = 0;
         end else begin
            wait_cnt++;
         end
      end
   end

   // Decoder model: goes busy after dec_start, idle again 3 cycles later.
   always @(negedge clk) begin
      if (reset) begin
         dec_ready = 1'b1;
         dec_busy  = 0;
      end else if (dec_busy > 0) begin
         dec_busy--;
         if (dec_busy == 0) dec_ready = 1'b1;
      end else if (dec_start) begin
         dlog_instr.push_back(dec_instr);
         dlog_pc.push_back(pc);
         dec_ready = 1'b0;
         if (!dec_stuck) dec_busy = 3;
      end
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic clear_img;
      for (int i = 0; i < 65536; i++) img[i] = 8'h00;
   endtask

   task automatic do_reset;
      reset         = 1'b1;
      enable        = 1'b0;
      pc_load       = 1'b0;
      pc_load_value = 16'h0000;
      ack_stop      = -1;
      mem_lat       = 0;
      dec_stuck     = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      ack_stop = addr_log.size();
      n_checks++; if (mem_req !== 1'b0)       begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
      n_checks++; if (mem_addr !== 16'h0000)  begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
      n_checks++; if (dec_start !== 1'b0)     begin n_fail++; $display("FAIL rst_dec_start: got %b want 0", dec_start); end
      n_checks++; if (dec_instr !== 16'h0000) begin n_fail++; $display("FAIL rst_dec_instr: got %h want 0000", dec_instr); end
      n_checks++; if (pc !== 16'h0000)        begin n_fail++; $display("FAIL rst_pc: got %h want 0000", pc); end
      n_checks++; if (halted !== 1'b0)        begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted); end
      n_checks++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      tick();
      n_checks++; if (mem_req !== 1'b1)       begin n_fail++; $display("FAIL first_req: got %b want 1", mem_req); end
      n_checks++; if (mem_addr !== 16'h0000)  begin n_fail++; $display("FAIL first_addr: got %h want 0000", mem_addr); end
   endtask

   task automatic test_program;
      int abase, dbase, k, highs;
      do_reset();
      clear_img();
      img[0] = 8'h60; img[1] = 8'h10; img[2] = 8'h07; img[3] = 8'hAC;
      mem_lat = 1;
      abase = addr_log.size();
      dbase = dlog_instr.size();
      enable = 1'b1;
      k = 0;
      while (!halted && k < 300) begin tick(); k++; end
      n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL prog_halted: got %b want 1", halted); end
      n_checks++; if (dlog_instr.size() - dbase != 3) begin n_fail++; $display("FAIL prog_ndisp: got %0d want 3", dlog_instr.size() - dbase); end
      if (dlog_instr.size() - dbase == 3) begin
         n_checks++; if (dlog_instr[dbase] !== 16'h6000)   begin n_fail++; $display("FAIL prog_i0: got %h want 6000", dlog_instr[dbase]); end
         n_checks++; if (dlog_pc[dbase] !== 16'h0000)      begin n_fail++; $display("FAIL prog_pc0: got %h want 0000", dlog_pc[dbase]); end
         n_checks++; if (dlog_instr[dbase+1] !== 16'h1007) begin n_fail++; $display("FAIL prog_i1: got %h want 1007", dlog_instr[dbase+1]); end
         n_checks++; if (dlog_pc[dbase+1] !== 16'h0001)    begin n_fail++; $display("FAIL prog_pc1: got %h want 0001", dlog_pc[dbase+1]); end
         n_checks++; if (dlog_instr[dbase+2] !== 16'hAC00) begin n_fail++; $display("FAIL prog_i2: got %h want AC00", dlog_instr[dbase+2]); end
         n_checks++; if (dlog_pc[dbase+2] !== 16'h0003)    begin n_fail++; $display("FAIL prog_pc2: got %h want 0003", dlog_pc[dbase+2]); end
      end
      n_checks++; if (pc !== 16'h0004) begin n_fail++; $display("FAIL prog_pc_end: got %h want 0004", pc); end
      n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL prog_busy: got %b want 0", busy); end
      n_checks++; if (addr_log.size() - abase < 4 || addr_log[abase+3] !== 16'h0003)
                     begin n_fail++; $display("FAIL prog_fetch_order: got %0d acks want >=4 ending at addr 0003", addr_log.size() - abase); end
      repeat (5) tick();
      highs = 0;
      for (int i = 0; i < 20; i++) begin tick(); if (mem_req) highs++; end
      n_checks++; if (highs != 0) begin n_fail++; $display("FAIL halt_no_fetch: got %0d req cycles want 0", highs); end
      // Reload onto the return opcode and halt again.
      pc_load = 1'b1; pc_load_value = 16'h0003;
      tick();
      pc_load = 1'b0;
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reload_halted: got %b want 0", halted); end
      n_checks++; if (pc !== 16'h0003) begin n_fail++; $display("FAIL reload_pc: got %h want 0003", pc); end
      k = 0;
      while (!halted && k < 100) begin tick(); k++; end
      n_checks++; if (halted !== 1'b1 || pc !== 16'h0004) begin n_fail++; $display("FAIL reload_end: got halted=%b pc=%h want 1/0004", halted, pc); end
      n_checks++; if (dlog_instr[dlog_instr.size()-1] !== 16'hAC00) begin n_fail++; $display("FAIL reload_instr: got %h want AC00", dlog_instr[dlog_instr.size()-1]); end
   endtask

   task automatic test_fifo_full;
      int abase, highs;
      do_reset();
      clear_img();
      ack_stop = addr_log.size();
      abase = addr_log.size();
      repeat (5) tick();
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin n_fail++; $display("FAIL hold_req: got req=%b addr=%h want 1/0000", mem_req, mem_addr); end
      ack_stop = -1;
      repeat (30) tick();
      n_checks++; if (addr_log.size() - abase != 4) begin n_fail++; $display("FAIL full_count: got %0d bytes want 4", addr_log.size() - abase); end
      highs = 0;
      for (int i = 0; i < 10; i++) begin tick(); if (mem_req) highs++; end
      n_checks++; if (highs != 0) begin n_fail++; $display("FAIL full_no_req: got %0d req cycles want 0", highs); end
      n_checks++; if (busy !== 1'b0 || pc !== 16'h0000) begin n_fail++; $display("FAIL disabled_idle: got busy=%b pc=%h want 0/0000", busy, pc); end
   endtask

   task automatic test_two_byte_wait;
      int dbase, k;
      do_reset();
      clear_img();
      img[0] = 8'h18; img[1] = 8'h05;
      ack_stop = addr_log.size() + 1;
      dbase = dlog_instr.size();
      enable = 1'b1;
      repeat (20) tick();
      n_checks++; if (dlog_instr.size() != dbase) begin n_fail++; $display("FAIL two_byte_early: got %0d starts want 0", dlog_instr.size() - dbase); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL two_byte_busy: got %b want 0", busy); end
      ack_stop = addr_log.size() + 1;
      k = 0;
      while (dlog_instr.size() == dbase && k < 20) begin tick(); k++; end
      n_checks++; if (dlog_instr.size() != dbase + 1) begin n_fail++; $display("FAIL two_byte_start: got %0d starts want 1", dlog_instr.size() - dbase); end
      else begin
         n_checks++; if (dlog_instr[dbase] !== 16'h1805) begin n_fail++; $display("FAIL two_byte_instr: got %h want 1805", dlog_instr[dbase]); end
      end
      repeat (10) tick();
      n_checks++; if (pc !== 16'h0002) begin n_fail++; $display("FAIL two_byte_pc: got %h want 0002", pc); end
   endtask

   task automatic test_pc_load_discard;
      int abase, dbase, k;
      do_reset();
      clear_img();
      img[16'hFFFE] = 8'h11; img[16'hFFFF] = 8'h22; img[0] = 8'h33; img[1] = 8'h44;
      ack_stop = addr_log.size();
      repeat (3) tick();
      abase = addr_log.size();
      pc_load = 1'b1; pc_load_value = 16'hFFFE; ack_stop = -1;
      tick();
      pc_load = 1'b0;
      repeat (20) tick();
      n_checks++; if (addr_log.size() - abase != 5) begin n_fail++; $display("FAIL discard_nacks: got %0d want 5", addr_log.size() - abase); end
      else begin
         n_checks++; if (addr_log[abase+1] !== 16'hFFFE) begin n_fail++; $display("FAIL reload_addr0: got %h want FFFE", addr_log[abase+1]); end
         n_checks++; if (addr_log[abase+2] !== 16'hFFFF) begin n_fail++; $display("FAIL reload_addr1: got %h want FFFF", addr_log[abase+2]); end
         n_checks++; if (addr_log[abase+3] !== 16'h0000) begin n_fail++; $display("FAIL reload_wrap: got %h want 0000", addr_log[abase+3]); end
      end
      n_checks++; if (pc !== 16'hFFFE) begin n_fail++; $display("FAIL load_pc: got %h want FFFE", pc); end
      dbase = dlog_instr.size();
      enable = 1'b1;
      k = 0;
      while (dlog_instr.size() < dbase + 2 && k < 40) begin tick(); k++; end
      n_checks++; if (dlog_instr.size() < dbase + 2) begin n_fail++; $display("FAIL discard_ndisp: got %0d want 2", dlog_instr.size() - dbase); end
      else begin
         n_checks++; if (dlog_instr[dbase] !== 16'h1100 || dlog_pc[dbase] !== 16'hFFFE)
            begin n_fail++; $display("FAIL discard_first: got %h@%h want 1100@FFFE", dlog_instr[dbase], dlog_pc[dbase]); end
         n_checks++; if (dlog_instr[dbase+1] !== 16'h2200 || dlog_pc[dbase+1] !== 16'hFFFF)
            begin n_fail++; $display("FAIL discard_second: got %h@%h want 2200@FFFF", dlog_instr[dbase+1], dlog_pc[dbase+1]); end
      end
   endtask

   task automatic test_pc_load_ignored;
      int dbase, k;
      do_reset();
      clear_img();
      img[0] = 8'h60; img[1] = 8'h61;
      dbase = dlog_instr.size();
      enable = 1'b1;
      k = 0;
      while (dlog_instr.size() == dbase && k < 40) begin tick(); k++; end
      tick();
      tick();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wait_done_busy: got %b want 1", busy); end
      pc_load = 1'b1; pc_load_value = 16'h1234;
      tick();
      pc_load = 1'b0;
      n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL ignored_pc_now: got %h want 0000", pc); end
      k = 0;
      while (dlog_instr.size() < dbase + 2 && k < 40) begin tick(); k++; end
      n_checks++; if (dlog_instr.size() < dbase + 2) begin n_fail++; $display("FAIL ignored_ndisp: got %0d want 2", dlog_instr.size() - dbase); end
      else begin
         n_checks++; if (dlog_instr[dbase+1] !== 16'h6100 || dlog_pc[dbase+1] !== 16'h0001)
            begin n_fail++; $display("FAIL ignored_next: got %h@%h want 6100@0001", dlog_instr[dbase+1], dlog_pc[dbase+1]); end
      end
   endtask

   task automatic test_reset_midop;
      int dbase, k;
      do_reset();
      clear_img();
      mem_lat = 2;
      enable  = 1'b1;
      repeat (7) tick();
      reset = 1'b1;
      tick();
      n_checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || dec_start !== 1'b0 || halted !== 1'b0)
         begin n_fail++; $display("FAIL midrst_ctrl: got req=%b busy=%b start=%b halted=%b want 0000", mem_req, busy, dec_start, halted); end
      n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL midrst_pc: got %h want 0000", pc); end
      reset = 1'b0;
      dbase = dlog_instr.size();
      k = 0;
      while (dlog_instr.size() == dbase && k < 60) begin tick(); k++; end
      n_checks++; if (dlog_instr.size() == dbase || dlog_pc[dbase] !== 16'h0000)
         begin n_fail++; $display("FAIL midrst_restart: got %0d starts, want first at pc 0000", dlog_instr.size() - dbase); end
   endtask

`ifdef DEC_WATCHDOG_EN
   task automatic test_watchdog;
      int dbase, k;
      do_reset();
      clear_img();
      img[0] = 8'h60;
      dec_stuck = 1'b1;
      dbase = dlog_instr.size();
      enable = 1'b1;
      k = 0;
      while (dlog_instr.size() == dbase && k < 40) begin tick(); k++; end
      k = 0;
      while (!halted && k < 400) begin tick(); k++; end
      n_checks++; if (k != 257) begin n_fail++; $display("FAIL wd_latency: got %0d cycles want 257", k); end
      n_checks++; if (dec_timeout !== 1'b1 || halted !== 1'b1) begin n_fail++; $display("FAIL wd_flags: got to=%b halted=%b want 1/1", dec_timeout, halted); end
      n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL wd_pc: got %h want 0000", pc); end
      pc_load = 1'b1; pc_load_value = 16'h0000;
      tick();
      pc_load = 1'b0; enable = 1'b0;
      n_checks++; if (dec_timeout !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL wd_clear: got to=%b halted=%b want 0/0", dec_timeout, halted); end
      do_reset();
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      test_reset();
      test_program();
      test_fifo_full();
      test_two_byte_wait();
      test_pc_load_discard();
      test_pc_load_ignored();
      test_reset_midop();
`ifdef DEC_WATCHDOG_EN
      test_watchdog();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
